// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
//   Shared types and encodings for the RAMIO port arbiter.
//   - state_t      : arbiter FSM states (IDLE -> ACTIVE -> DONE -> IDLE)
//   - WT_* / RT_*  : RAMIO write_type / read_type encodings
//   - ram_req_t    : one captured request (write_type, read_type, address, data_in)
//   - is_read()    : true when a read_type actually reads (size field non-zero)
//   The request struct is sized for the widest supported bus (REQ_ADDR_BITS /
//   REQ_DATA_BITS); narrower arbiter instances zero-extend into it.
package ram_arbiter_pkg;

   localparam int REQ_ADDR_BITS = 32;
   localparam int REQ_DATA_BITS = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // write_type encoding
   localparam logic [1:0] WT_NONE = 2'b00;
   localparam logic [1:0] WT_B    = 2'b01;
   localparam logic [1:0] WT_H    = 2'b10;
   localparam logic [1:0] WT_W    = 2'b11;

   // read_type[1:0] size encoding; read_type[2] selects sign extension
   localparam logic [1:0] RT_SIZE_NONE = 2'b00;
   localparam logic [1:0] RT_SIZE_B    = 2'b01;
   localparam logic [1:0] RT_SIZE_H    = 2'b10;
   localparam logic [1:0] RT_SIZE_W    = 2'b11;

   typedef struct packed {
      logic [1:0]               write_type;
      logic [2:0]               read_type;
      logic [REQ_ADDR_BITS-1:0] address;
      logic [REQ_DATA_BITS-1:0] data_in;
   } ram_req_t;

   function automatic logic is_read(input logic [2:0] read_type);
      return read_type[1:0] != RT_SIZE_NONE;
   endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares the single RAMIO port between instruction fetch (port 0) and
//   data load/store (port 1). One transaction at a time; the downstream
//   address/type are held constant while the transaction is ACTIVE.
//
//   Handshake: reqN is a level, held together with its fields until ackN.
//   ackN is a one-cycle completion strobe; rdata is valid in that cycle and
//   holds its value afterwards. A req dropped before its ack still gets its
//   transaction finished and acked.
//
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   reqN, reqN_write_type/read_type,
//   reqN_address, reqN_data_in         requester N (0 = fetch, 1 = data)
//   ackN                               one-cycle completion pulse for port N
//   rdata                              registered read result (0 for writes/aborts)
//   error                              sticky watchdog-abort flag
//   ram_enable/write_type/read_type/
//   ram_address/ram_data_in            downstream request, zero outside ACTIVE
//   ram_data_out, ram_data_out_ready,
//   ram_busy                           downstream response
//   dbg_state                          current FSM state (state_t encoding)
module ram_port_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDRESS_BITWIDTH = REQ_ADDR_BITS,
   parameter int DATA_WIDTH       = REQ_DATA_BITS,
   parameter int ROUND_ROBIN      = 1,
   parameter int TIMEOUT_CYCLES   = 256
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req0,
   input  logic [1:0]                  req0_write_type,
   input  logic [2:0]                  req0_read_type,
   input  logic [ADDRESS_BITWIDTH-1:0] req0_address,
   input  logic [DATA_WIDTH-1:0]       req0_data_in,
   input  logic                        req1,
   input  logic [1:0]                  req1_write_type,
   input  logic [2:0]                  req1_read_type,
   input  logic [ADDRESS_BITWIDTH-1:0] req1_address,
   input  logic [DATA_WIDTH-1:0]       req1_data_in,
   output logic                        ack0,
   output logic                        ack1,
   output logic [DATA_WIDTH-1:0]       rdata,
   output logic                        error,
   output logic                        ram_enable,
   output logic [1:0]                  ram_write_type,
   output logic [2:0]                  ram_read_type,
   output logic [ADDRESS_BITWIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0]       ram_data_in,
   input  logic [DATA_WIDTH-1:0]       ram_data_out,
   input  logic                        ram_data_out_ready,
   input  logic                        ram_busy,
   output logic [1:0]                  dbg_state
);

   state_t                state_q, state_d;
   ram_req_t              cur_q;
   ram_req_t              req0_pkt, req1_pkt;
   logic                  port_q;      // port owning the current transaction
   logic                  rr_pref_q;   // port favoured on the next tie
   logic [31:0]           wd_q;        // ACTIVE cycles spent without completing
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  error_q;

   logic any_req;
   logic winner;
   logic complete;
   logic timeout;

   // Capture both requests in the common struct form.
   always_comb begin
      req0_pkt            = '0;
      req0_pkt.write_type = req0_write_type;
      req0_pkt.read_type  = req0_read_type;
      req0_pkt.address    = REQ_ADDR_BITS'(req0_address);
      req0_pkt.data_in    = REQ_DATA_BITS'(req0_data_in);
      req1_pkt            = '0;
      req1_pkt.write_type = req1_write_type;
      req1_pkt.read_type  = req1_read_type;
      req1_pkt.address    = REQ_ADDR_BITS'(req1_address);
      req1_pkt.data_in    = REQ_DATA_BITS'(req1_data_in);
   end

   // On a tie the data port wins unless round-robin alternation is enabled.
   always_comb begin
      any_req = req0 | req1;
      if (req0 && req1) begin
         winner = (ROUND_ROBIN != 0) ? rr_pref_q : 1'b1;
      end else begin
         winner = req1;
      end
   end

   // Writes (and no-op reads) finish as soon as the port is not busy; reads
   // additionally need the data strobe. Both come combinationally from
   // downstream in the same cycle.
   assign complete = !ram_busy && (!is_read(cur_q.read_type) || ram_data_out_ready);
   assign timeout  = (TIMEOUT_CYCLES != 0) && (wd_q == 32'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (any_req) state_d = ST_ACTIVE;
         ST_ACTIVE: if (complete || timeout) state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_q     <= '0;
         port_q    <= 1'b0;
         rr_pref_q <= 1'b0;
         wd_q      <= '0;
         rdata_q   <= '0;
         error_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (any_req) begin
                  cur_q  <= winner ? req1_pkt : req0_pkt;
                  port_q <= winner;
                  wd_q   <= '0;
               end
            end
            ST_ACTIVE: begin
               if (complete) begin
                  rdata_q <= is_read(cur_q.read_type) ? ram_data_out : '0;
               end else if (timeout) begin
                  rdata_q <= '0;
                  error_q <= 1'b1;
               end else begin
                  wd_q <= wd_q + 32'd1;
               end
            end
            ST_DONE: begin
               rr_pref_q <= ~port_q;
            end
            default: ;
         endcase
      end
   end

   // Downstream bus is only driven while ACTIVE so I/O side effects
   // (UART read/write, LED write) happen once per transaction.
   always_comb begin
      ram_enable     = 1'b0;
      ram_write_type = WT_NONE;
      ram_read_type  = 3'b000;
      ram_address    = '0;
      ram_data_in    = '0;
      ack0           = 1'b0;
      ack1           = 1'b0;
      if (state_q == ST_ACTIVE) begin
         ram_enable     = 1'b1;
         ram_write_type = cur_q.write_type;
         ram_read_type  = cur_q.read_type;
         ram_address    = cur_q.address[ADDRESS_BITWIDTH-1:0];
         ram_data_in    = cur_q.data_in[DATA_WIDTH-1:0];
      end
      if (state_q == ST_DONE) begin
         ack0 = ~port_q;
         ack1 = port_q;
      end
   end

   assign rdata     = rdata_q;
   assign error     = error_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (defaults: RR=1, timeout 256) ----------------
  logic        req0 = 0, req1 = 0;
  logic [1:0]  req0_write_type = 0, req1_write_type = 0;
  logic [2:0]  req0_read_type = 0, req1_read_type = 0;
  logic [31:0] req0_address = 0, req1_address = 0;
  logic [31:0] req0_data_in = 0, req1_data_in = 0;
  logic        ack0, ack1, error, ram_enable;
  logic [31:0] rdata, ram_address, ram_data_in;
  logic [1:0]  ram_write_type, dbg_state;
  logic [2:0]  ram_read_type;
  logic [31:0] ram_data_out = 0;
  logic        ram_data_out_ready = 0, ram_busy = 0;

  ram_port_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req0_write_type(req0_write_type), .req0_read_type(req0_read_type),
    .req0_address(req0_address), .req0_data_in(req0_data_in),
    .req1(req1), .req1_write_type(req1_write_type), .req1_read_type(req1_read_type),
    .req1_address(req1_address), .req1_data_in(req1_data_in),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .error(error),
    .ram_enable(ram_enable), .ram_write_type(ram_write_type), .ram_read_type(ram_read_type),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .ram_data_out_ready(ram_data_out_ready),
    .ram_busy(ram_busy), .dbg_state(dbg_state)
  );

  // ---------------- watchdog DUT (timeout 8) ----------------
  logic        w_req0 = 0, w_req1 = 0;
  logic [2:0]  w_rt = 0;
  logic [31:0] w_addr = 0, w_dout = 0;
  logic        w_ready = 0, w_busy = 0;
  logic        w_ack0, w_ack1, w_error, w_enable;
  logic [31:0] w_rdata, w_ram_address, w_ram_data_in;
  logic [1:0]  w_ram_write_type, w_dbg_state;
  logic [2:0]  w_ram_read_type;

  ram_port_arbiter #(.TIMEOUT_CYCLES(8)) u_wd (
    .clk(clk), .rst_n(rst_n),
    .req0(w_req0), .req0_write_type(2'b00), .req0_read_type(3'b000),
    .req0_address(32'd0), .req0_data_in(32'd0),
    .req1(w_req1), .req1_write_type(2'b00), .req1_read_type(w_rt),
    .req1_address(w_addr), .req1_data_in(32'd0),
    .ack0(w_ack0), .ack1(w_ack1), .rdata(w_rdata), .error(w_error),
    .ram_enable(w_enable), .ram_write_type(w_ram_write_type), .ram_read_type(w_ram_read_type),
    .ram_address(w_ram_address), .ram_data_in(w_ram_data_in),
    .ram_data_out(w_dout), .ram_data_out_ready(w_ready),
    .ram_busy(w_busy), .dbg_state(w_dbg_state)
  );

  // ---------------- reference model state ----------------
  logic [1:0]  m_wt[2];
  logic [2:0]  m_rt[2];
  logic [31:0] m_addr[2];
  logic [31:0] m_din[2];
  bit          m_pref = 0;     // port that wins the next tie
  int          last_ack_cyc = 0;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) return m_pref ? 1 : 0;
    return r1 ? 1 : 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int p, input logic [1:0] wt, input logic [2:0] rt,
                         input logic [31:0] a, input logic [31:0] d);
    m_wt[p] = wt; m_rt[p] = rt; m_addr[p] = a; m_din[p] = d;
    if (p == 0) begin
      req0_write_type = wt; req0_read_type = rt; req0_address = a; req0_data_in = d; req0 = 1;
    end else begin
      req1_write_type = wt; req1_read_type = rt; req1_address = a; req1_data_in = d; req1 = 1;
    end
  endtask

  // Downstream responder for one transaction owned by port p: busy for d
  // cycles, then completes with dout. Checks grant latency, held fields,
  // ack placement and rdata.
  task automatic serve(input int p, input int d, input logic [31:0] dout,
                       input bit drop, input int exp_lat);
    int lat;
    int act;
    logic [31:0] exp_rd;
    exp_rd = (m_rt[p][1:0] != 2'b00) ? dout : 32'd0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ram_enable && lat < 40);
    chk("grant_latency", 64'(lat), 64'(exp_lat));
    if (!ram_enable) return;
    act = 1;
    chk("bus_addr", ram_address, m_addr[p]);
    chk("bus_wt", ram_write_type, m_wt[p]);
    chk("bus_rt", ram_read_type, m_rt[p]);
    chk("bus_din", ram_data_in, m_din[p]);
    ram_busy = (d > 0);
    ram_data_out_ready = (d == 0);
    ram_data_out = (d == 0) ? dout : $urandom;
    for (int j = 1; j <= d; j++) begin
      @(negedge clk);
      if (ram_enable) act++;
      chk("hold_addr", ram_address, m_addr[p]);
      chk("early_ack", {ack0, ack1}, 0);
      if (j == d) begin
        ram_busy = 0; ram_data_out_ready = 1; ram_data_out = dout;
      end
    end
    @(negedge clk);
    chk("active_cycles", 64'(act), 64'(d + 1));
    chk("ack_own", (p == 1) ? ack1 : ack0, 1);
    chk("ack_other", (p == 1) ? ack0 : ack1, 0);
    chk("rdata", rdata, exp_rd);
    chk("done_bus_idle", {ram_enable, ram_write_type, ram_read_type}, 0);
    ram_busy = 0; ram_data_out_ready = 0; ram_data_out = $urandom;
    if (drop) begin
      if (p == 1) req1 = 0; else req0 = 0;
    end
    m_pref = (p == 0);
    last_ack_cyc = cyc;
  endtask

  // ---------------- stimulus ----------------
  int prev_ack;
  int act;
  int n;
  bit r0, r1, first;
  int w;
  logic [31:0] hold_rdata;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ack", {ack0, ack1}, 0);
    chk("reset_enable", ram_enable, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_error", error, 0);
    chk("reset_state", dbg_state, 0);
    rst_n = 1;

    // Both ports held: grants alternate 0,1,0,1, three cycles apart.
    set_req(0, 2'b00, 3'b011, 32'h0000_0010, 32'h0);
    set_req(1, 2'b11, 3'b000, 32'h0000_0800, 32'hA5A5_0001);
    prev_ack = 0;
    for (int i = 0; i < 4; i++) begin
      w = i % 2;
      serve(w, 0, 32'h1000_0000 + 32'(i), 0, (i == 0) ? 1 : 2);
      if (i > 0) chk("rr_ack_spacing", 64'(last_ack_cyc - prev_ack), 3);
      prev_ack = last_ack_cyc;
    end
    req0 = 0; req1 = 0;

    // Single fetch read: ack two cycles after the request edge.
    @(negedge clk);
    set_req(0, 2'b00, 3'b011, 32'h0000_0100, 32'h0);
    serve(0, 0, 32'hDEAD_BEEF, 1, 1);

    // UART byte write: write strobe present for exactly one cycle, rdata 0.
    @(negedge clk);
    set_req(1, 2'b01, 3'b000, 32'hFFFF_FFFE, 32'h0000_0041);
    serve(1, 0, 32'h7777_7777, 1, 1);

    // Cache miss: busy for 10 cycles, address held throughout.
    @(negedge clk);
    set_req(1, 2'b00, 3'b011, 32'h0000_2000, 32'h0);
    serve(1, 10, 32'h1234_5678, 1, 1);

    // rdata holds outside DONE.
    hold_rdata = rdata;
    repeat (2) @(negedge clk);
    chk("rdata_hold", rdata, hold_rdata);

    // Randomized traffic against the model.
    for (int it = 0; it < 24; it++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1;
      @(negedge clk);
      if (r0) set_req(0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom);
      if (r1) set_req(1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom);
      first = 1;
      while (r0 || r1) begin
        w = pick(r0, r1);
        serve(w, $urandom_range(0, 4), $urandom, 1, first ? 1 : 2);
        if (w == 1) r1 = 0; else r0 = 0;
        first = 0;
      end
    end

    // Asynchronous reset in the middle of an ACTIVE transaction.
    @(negedge clk);
    set_req(0, 2'b00, 3'b011, 32'h0000_0300, 32'h0);
    ram_busy = 1;
    @(negedge clk);
    chk("pre_reset_active", ram_enable, 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_enable", ram_enable, 0);
    chk("async_rst_addr", ram_address, 0);
    chk("async_rst_ack", {ack0, ack1}, 0);
    chk("async_rst_rdata", rdata, 0);
    chk("async_rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1; ram_busy = 0;
    m_pref = 0;
    serve(0, 0, 32'h5A5A_0001, 1, 1);
    chk("main_error_clear", error, 0);

    // Watchdog on the timeout-8 instance with busy stuck high.
    @(negedge clk);
    w_req1 = 1; w_rt = 3'b011; w_addr = 32'h0000_0040; w_busy = 1; w_ready = 0;
    w_dout = 32'hFFFF_0000;
    act = 0; n = 0;
    while (!w_ack1 && n < 40) begin
      @(negedge clk);
      if (w_enable) act++;
      n++;
    end
    chk("wd_ack", w_ack1, 1);
    chk("wd_active_cycles", 64'(act), 8);
    chk("wd_rdata", w_rdata, 0);
    chk("wd_error", w_error, 1);
    w_req1 = 0; w_busy = 0;
    repeat (3) @(negedge clk);
    chk("wd_error_sticky", w_error, 1);
    w_req1 = 1; w_ready = 1; w_dout = 32'hCAFE_F00D;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!w_ack1 && n < 10);
    w_req1 = 0;
    chk("wd_next_latency", 64'(n), 2);
    chk("wd_next_rdata", w_rdata, 32'hCAFE_F00D);
    chk("wd_error_still", w_error, 1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
